// File: rtl/dmem_pkg.sv
// Shared types for the data-memory arbiter.
//   MEM_ADDR_W / WORD_W : memory geometry (4096 x 32)
//   owner_e             : which requester owns the read issued last cycle
//   mem_req_t           : payload driven onto the memory port by the winner
package dmem_pkg;

  localparam int unsigned MEM_ADDR_W = 12;
  localparam int unsigned WORD_W     = 32;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DMA  = 2'd2
  } owner_e;

  typedef struct packed {
    logic                  we;
    logic [MEM_ADDR_W-1:0] addr;
    logic [WORD_W-1:0]     wdata;
  } mem_req_t;

endpackage

// File: rtl/dmem_starve_cnt.sv
// Saturating count of consecutive denied DMA cycles.
//   clock, reset : clock and synchronous active-high reset
//   inc          : DMA requested but was not granted this cycle
//   clr          : DMA granted, or not requesting (clear has priority)
//   sat          : registered, high while the count equals LIMIT
module dmem_starve_cnt #(
  parameter int unsigned LIMIT = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic sat
);

  localparam int unsigned CNT_W = $clog2(LIMIT + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sat_q, sat_d;

  // Next count; sat is decoded from the next value so it can be a flop.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != CNT_W'(LIMIT))) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    sat_d = (cnt_d == CNT_W'(LIMIT));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
      sat_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sat_q <= sat_d;
    end
  end

  assign sat = sat_q;

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data-memory arbiter between the CPU MEM stage and a DMA port.
//   clock, reset         : clock and synchronous active-high reset
//   cpu_req/we/addr/wdata: CPU access, held until cpu_stall is low
//   cpu_rdata, cpu_stall : CPU load data (response cycle) and stall
//   dma_req/we/addr/wdata: DMA access, held until dma_gnt
//   dma_gnt              : DMA access issued this cycle
//   dma_rvalid/dma_rdata : DMA read response, one cycle after issue
//   mem_*                : memory port; synchronous read, 1-cycle latency
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W       = MEM_ADDR_W,
  parameter int unsigned DATA_W       = WORD_W,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  owner_e   rd_owner_q, rd_owner_d;
  logic     cpu_done_q, cpu_done_d;
  logic     cpu_elig;
  logic     cpu_win;
  logic     dma_win;
  logic     starve_sat;
  logic     starve_inc;
  logic     starve_clr;
  mem_req_t sel;

  dmem_starve_cnt #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clock (clock),
    .reset (reset),
    .inc   (starve_inc),
    .clr   (starve_clr),
    .sat   (starve_sat)
  );

  // Grant, memory issue, stall and response muxing.
  always_comb begin
    rd_owner_d = OWN_NONE;
    cpu_done_d = 1'b0;
    sel        = '0;
    mem_en     = 1'b0;
    cpu_rdata  = '0;
    dma_rdata  = '0;
    dma_rvalid = 1'b0;

    // A CPU load whose response returns this cycle must not be reissued.
    cpu_elig = cpu_req & ~cpu_done_q;
    dma_win  = ~reset & dma_req & (~cpu_elig | starve_sat);
    cpu_win  = ~reset & cpu_elig & ~dma_win;

    if (cpu_win) begin
      mem_en    = 1'b1;
      sel.we    = cpu_we;
      sel.addr  = MEM_ADDR_W'(cpu_addr);
      sel.wdata = WORD_W'(cpu_wdata);
      if (!cpu_we) begin
        rd_owner_d = OWN_CPU;
        cpu_done_d = 1'b1;
      end
    end else if (dma_win) begin
      mem_en    = 1'b1;
      sel.we    = dma_we;
      sel.addr  = MEM_ADDR_W'(dma_addr);
      sel.wdata = WORD_W'(dma_wdata);
      if (!dma_we) begin
        rd_owner_d = OWN_DMA;
      end
    end

    mem_we    = sel.we;
    mem_addr  = ADDR_W'(sel.addr);
    mem_wdata = DATA_W'(sel.wdata);
    dma_gnt   = dma_win;

    // Stall on a load issue cycle, or when denied outside the response cycle.
    cpu_stall = ~reset & cpu_req &
                ((cpu_win & ~cpu_we) | (~cpu_win & ~cpu_done_q));

    // Response of last cycle's read; dropped entirely while in reset.
    if (!reset) begin
      case (rd_owner_q)
        OWN_CPU: cpu_rdata = mem_rdata;
        OWN_DMA: begin
          dma_rvalid = 1'b1;
          dma_rdata  = mem_rdata;
        end
        default: ;
      endcase
    end

    starve_inc = dma_req & ~dma_win;
    starve_clr = dma_win | ~dma_req;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_owner_q <= OWN_NONE;
      cpu_done_q <= 1'b0;
    end else begin
      rd_owner_q <= rd_owner_d;
      cpu_done_q <= cpu_done_d;
    end
  end

endmodule
